// File: rtl/bus_host_arbiter.sv
// Round-robin arbiter that lets NrHosts bus hosts share one req/gnt/rvalid port and routes in-order responses back.
// Optional response watchdog is compiled in with `define BUS_HOST_ARBITER_WATCHDOG_EN.
module bus_host_arbiter #(
  parameter int NrHosts        = 2,
  parameter int DataWidth      = 32,
  parameter int AddressWidth   = 32,
  parameter int MaxOutstanding = 4,
  parameter int TimeoutCycles  = 1024
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NrHosts-1:0]                host_req_i,
  output logic [NrHosts-1:0]                host_gnt_o,
  input  logic [NrHosts*AddressWidth-1:0]   host_addr_i,
  input  logic [NrHosts-1:0]                host_we_i,
  input  logic [NrHosts*DataWidth/8-1:0]    host_be_i,
  input  logic [NrHosts*DataWidth-1:0]      host_wdata_i,
  output logic [NrHosts-1:0]                host_rvalid_o,
  output logic [DataWidth-1:0]              host_rdata_o,
  output logic [NrHosts-1:0]                host_err_o,
  output logic                              dev_req_o,
  input  logic                              dev_gnt_i,
  output logic [AddressWidth-1:0]           dev_addr_o,
  output logic                              dev_we_o,
  output logic [DataWidth/8-1:0]            dev_be_o,
  output logic [DataWidth-1:0]              dev_wdata_o,
  input  logic                              dev_rvalid_i,
  input  logic [DataWidth-1:0]              dev_rdata_i,
  input  logic                              dev_err_i,
  output logic                              spurious_o
);

  localparam int HostW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int PtrW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int CntW  = PtrW + 1;
  localparam int BeW   = DataWidth / 8;

  logic [HostW-1:0] r_rr_ptr;
  logic [HostW-1:0] r_fifo [MaxOutstanding];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [CntW-1:0]  r_count;
  logic             r_spurious;

  logic [HostW-1:0] w_sel;
  logic [HostW-1:0] w_rr_next;
  logic [HostW-1:0] w_head;
  logic             w_any_req;
  logic             w_full;
  logic             w_empty;
  logic             w_accept;
  logic             w_pop_real;
  logic             w_pop;
  logic             w_timeout;
  logic             w_credit_eat;
  logic             w_spur;
  logic             w_resp_vld;
  logic             w_resp_err;
  logic [DataWidth-1:0] w_resp_data;

  // Pick the requester closest to r_rr_ptr going upward with wrap.
  always_comb begin
    int best;
    int off;
    best      = NrHosts;
    off       = 0;
    w_sel     = '0;
    w_any_req = 1'b0;
    for (int h = 0; h < NrHosts; h++) begin
      off = (h + NrHosts - int'(r_rr_ptr)) % NrHosts;
      if (host_req_i[h] && off < best) begin
        best      = off;
        w_sel     = HostW'(h);
        w_any_req = 1'b1;
      end
    end
  end

  assign w_rr_next = (w_sel == HostW'(NrHosts - 1)) ? '0 : w_sel + 1'b1;
  assign w_full    = (r_count == CntW'(MaxOutstanding));
  assign w_empty   = (r_count == '0);
  assign w_head    = r_fifo[r_rd_ptr];

  assign dev_req_o = w_any_req & ~w_full & ~rst_i;
  assign w_accept  = dev_req_o & dev_gnt_i;

  always_comb begin
    dev_addr_o  = '0;
    dev_we_o    = 1'b0;
    dev_be_o    = '0;
    dev_wdata_o = '0;
    host_gnt_o  = '0;
    for (int h = 0; h < NrHosts; h++) begin
      if (w_any_req && w_sel == HostW'(h)) begin
        dev_addr_o    = host_addr_i[h*AddressWidth +: AddressWidth];
        dev_we_o      = host_we_i[h];
        dev_be_o      = host_be_i[h*BeW +: BeW];
        dev_wdata_o   = host_wdata_i[h*DataWidth +: DataWidth];
        host_gnt_o[h] = w_accept;
      end
    end
  end

`ifdef BUS_HOST_ARBITER_WATCHDOG_EN
  localparam int WdW = $clog2(TimeoutCycles + 1);
  localparam int CrW = $clog2(MaxOutstanding + 1);

  logic [WdW-1:0] r_wd_cnt;
  logic [CrW-1:0] r_credit;

  // Late responses owed to timed-out entries are swallowed before any routing.
  assign w_credit_eat = dev_rvalid_i & (r_credit != '0) & ~rst_i;
  assign w_pop_real   = dev_rvalid_i & ~w_empty & ~w_credit_eat & ~rst_i;
  assign w_timeout    = ~w_empty & ~w_pop_real & ~rst_i & (r_wd_cnt == WdW'(TimeoutCycles - 1));
  assign w_spur       = dev_rvalid_i & w_empty & ~w_credit_eat & ~rst_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wd_cnt <= '0;
      r_credit <= '0;
    end else begin
      if (w_pop || w_empty) begin
        r_wd_cnt <= '0;
      end else begin
        r_wd_cnt <= r_wd_cnt + 1'b1;
      end
      if (w_timeout && !w_credit_eat) begin
        if (r_credit != CrW'(MaxOutstanding)) r_credit <= r_credit + 1'b1;
      end else if (w_credit_eat && !w_timeout) begin
        r_credit <= r_credit - 1'b1;
      end
    end
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TimeoutCycles != 0);
  assign w_credit_eat = 1'b0;
  assign w_timeout    = 1'b0;
  assign w_pop_real   = dev_rvalid_i & ~w_empty & ~rst_i;
  assign w_spur       = dev_rvalid_i & w_empty & ~rst_i;
`endif

  assign w_pop       = w_pop_real | w_timeout;
  assign w_resp_vld  = w_pop;
  assign w_resp_err  = w_pop_real ? dev_err_i : w_timeout;
  assign w_resp_data = w_pop_real ? dev_rdata_i : '0;

  always_comb begin
    host_rvalid_o = '0;
    host_err_o    = '0;
    for (int h = 0; h < NrHosts; h++) begin
      if (w_resp_vld && w_head == HostW'(h)) begin
        host_rvalid_o[h] = 1'b1;
        host_err_o[h]    = w_resp_err;
      end
    end
  end

  assign host_rdata_o = w_resp_data;
  assign spurious_o   = r_spurious;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_spurious <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_rr_ptr <= w_rr_next;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_spur) r_spurious <= 1'b1;
    end
  end

  // ID storage is data only; validity comes from the pointers and count.
  always_ff @(posedge clk_i) begin
    if (w_accept) r_fifo[r_wr_ptr] <= w_sel;
  end

endmodule

// File: tb/tb_bus_host_arbiter.sv
// Directed testbench for bus_host_arbiter (2 hosts, 4 outstanding, watchdog limit 16 when compiled in).
module tb_bus_host_arbiter;

  logic        clk;
  logic        rst_i;
  logic [1:0]  host_req_i;
  logic [1:0]  host_gnt_o;
  logic [63:0] host_addr_i;
  logic [1:0]  host_we_i;
  logic [7:0]  host_be_i;
  logic [63:0] host_wdata_i;
  logic [1:0]  host_rvalid_o;
  logic [31:0] host_rdata_o;
  logic [1:0]  host_err_o;
  logic        dev_req_o;
  logic        dev_gnt_i;
  logic [31:0] dev_addr_o;
  logic        dev_we_o;
  logic [3:0]  dev_be_o;
  logic [31:0] dev_wdata_o;
  logic        dev_rvalid_i;
  logic [31:0] dev_rdata_i;
  logic        dev_err_i;
  logic        spurious_o;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [1:0]  rr_gnt [5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
  logic [1:0]  rr_rv  [5] = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b10};
  logic [31:0] rr_dat [5] = '{32'h0, 32'hA0, 32'hB0, 32'hA1, 32'hB1};

  bus_host_arbiter #(
    .NrHosts(2), .DataWidth(32), .AddressWidth(32), .MaxOutstanding(4), .TimeoutCycles(16)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .host_req_i(host_req_i), .host_gnt_o(host_gnt_o), .host_addr_i(host_addr_i),
    .host_we_i(host_we_i), .host_be_i(host_be_i), .host_wdata_i(host_wdata_i),
    .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o), .host_err_o(host_err_o),
    .dev_req_o(dev_req_o), .dev_gnt_i(dev_gnt_i), .dev_addr_o(dev_addr_o),
    .dev_we_o(dev_we_o), .dev_be_o(dev_be_o), .dev_wdata_o(dev_wdata_o),
    .dev_rvalid_i(dev_rvalid_i), .dev_rdata_i(dev_rdata_i), .dev_err_i(dev_err_i),
    .spurious_o(spurious_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL tb_time_limit: simulation still running at %0t", $time);
    $fatal(1, "time limit");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    next_cycle();
    next_cycle();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    host_req_i = 2'b11; dev_gnt_i = 1'b1; dev_rvalid_i = 1'b1; dev_err_i = 1'b1; dev_rdata_i = 32'h1234;
    next_cycle();
    n_cmp++; if (host_gnt_o !== 2'b00) begin n_fail++; $display("FAIL rst_gnt: got %b want 00", host_gnt_o); end
    n_cmp++; if (dev_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_dev_req: got %b want 0", dev_req_o); end
    n_cmp++; if (host_rvalid_o !== 2'b00) begin n_fail++; $display("FAIL rst_rvalid: got %b want 00", host_rvalid_o); end
    n_cmp++; if (host_err_o !== 2'b00) begin n_fail++; $display("FAIL rst_err: got %b want 00", host_err_o); end
    n_cmp++; if (host_rdata_o !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", host_rdata_o); end
    n_cmp++; if (spurious_o !== 1'b0) begin n_fail++; $display("FAIL rst_spurious: got %b want 0", spurious_o); end
    host_req_i = 2'b00; dev_gnt_i = 1'b0; dev_rvalid_i = 1'b0; dev_err_i = 1'b0; dev_rdata_i = '0;
    next_cycle();
    rst_i = 1'b0;
    #1;
    n_cmp++; if (spurious_o !== 1'b0) begin n_fail++; $display("FAIL rst_release_spurious: got %b want 0", spurious_o); end
    next_cycle();
  endtask

  task automatic test_single();
    host_req_i = 2'b01; host_addr_i = {32'h0, 32'h0010_0000}; host_we_i = 2'b01;
    host_be_i = 8'h0F; host_wdata_i = {32'h0, 32'hDEADBEEF}; dev_gnt_i = 1'b1;
    #1;
    n_cmp++; if (host_gnt_o !== 2'b01) begin n_fail++; $display("FAIL single_gnt: got %b want 01", host_gnt_o); end
    n_cmp++; if (dev_req_o !== 1'b1) begin n_fail++; $display("FAIL single_dev_req: got %b want 1", dev_req_o); end
    n_cmp++; if (dev_addr_o !== 32'h0010_0000) begin n_fail++; $display("FAIL single_addr: got %h want 00100000", dev_addr_o); end
    n_cmp++; if (dev_we_o !== 1'b1) begin n_fail++; $display("FAIL single_we: got %b want 1", dev_we_o); end
    n_cmp++; if (dev_be_o !== 4'hF) begin n_fail++; $display("FAIL single_be: got %h want f", dev_be_o); end
    n_cmp++; if (dev_wdata_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_wdata: got %h want deadbeef", dev_wdata_o); end
    next_cycle();
    host_req_i = 2'b00; host_we_i = 2'b00; dev_gnt_i = 1'b0;
    dev_rvalid_i = 1'b1; dev_rdata_i = 32'h0000_5A5A; dev_err_i = 1'b0;
    #1;
    n_cmp++; if (host_rvalid_o !== 2'b01) begin n_fail++; $display("FAIL single_rvalid: got %b want 01", host_rvalid_o); end
    n_cmp++; if (host_rdata_o !== 32'h5A5A) begin n_fail++; $display("FAIL single_rdata: got %h want 00005a5a", host_rdata_o); end
    n_cmp++; if (host_err_o !== 2'b00) begin n_fail++; $display("FAIL single_err: got %b want 00", host_err_o); end
    next_cycle();
    dev_rvalid_i = 1'b0; dev_rdata_i = '0;
    host_req_i = 2'b11; host_addr_i = {32'h0000_2000, 32'h0000_1000};
    #1;
    n_cmp++; if (dev_addr_o !== 32'h2000) begin n_fail++; $display("FAIL single_rrptr_addr: got %h want 00002000", dev_addr_o); end
    n_cmp++; if (host_gnt_o !== 2'b00) begin n_fail++; $display("FAIL single_nogrant: got %b want 00", host_gnt_o); end
    n_cmp++; if (host_rdata_o !== 32'h0) begin n_fail++; $display("FAIL single_rdata_idle: got %h want 0", host_rdata_o); end
    next_cycle();
    host_req_i = 2'b00;
  endtask

  task automatic test_round_robin();
    do_reset();
    host_addr_i = {32'h0000_B000, 32'h0000_A000}; dev_gnt_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      host_req_i   = (k < 4) ? 2'b11 : 2'b00;
      dev_rvalid_i = (k >= 1);
      dev_rdata_i  = rr_dat[k];
      #1;
      n_cmp++; if (host_gnt_o !== rr_gnt[k]) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, host_gnt_o, rr_gnt[k]); end
      n_cmp++; if (host_rvalid_o !== rr_rv[k]) begin n_fail++; $display("FAIL rr_rvalid[%0d]: got %b want %b", k, host_rvalid_o, rr_rv[k]); end
      n_cmp++; if (host_rdata_o !== rr_dat[k]) begin n_fail++; $display("FAIL rr_rdata[%0d]: got %h want %h", k, host_rdata_o, rr_dat[k]); end
      next_cycle();
    end
    dev_rvalid_i = 1'b0; dev_gnt_i = 1'b0; dev_rdata_i = '0;
  endtask

  task automatic test_full();
    host_req_i = 2'b01; dev_gnt_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++; if (dev_req_o !== 1'b1) begin n_fail++; $display("FAIL full_fill_req[%0d]: got %b want 1", k, dev_req_o); end
      n_cmp++; if (host_gnt_o !== 2'b01) begin n_fail++; $display("FAIL full_fill_gnt[%0d]: got %b want 01", k, host_gnt_o); end
      next_cycle();
    end
    #1;
    n_cmp++; if (dev_req_o !== 1'b0) begin n_fail++; $display("FAIL full_blocked_req: got %b want 0", dev_req_o); end
    n_cmp++; if (host_gnt_o !== 2'b00) begin n_fail++; $display("FAIL full_blocked_gnt: got %b want 00", host_gnt_o); end
    next_cycle();
    dev_rvalid_i = 1'b1; dev_rdata_i = 32'h11;
    #1;
    n_cmp++; if (dev_req_o !== 1'b0) begin n_fail++; $display("FAIL full_pop_cycle_req: got %b want 0", dev_req_o); end
    n_cmp++; if (host_rvalid_o !== 2'b01) begin n_fail++; $display("FAIL full_pop_rvalid: got %b want 01", host_rvalid_o); end
    next_cycle();
    dev_rvalid_i = 1'b0;
    #1;
    n_cmp++; if (dev_req_o !== 1'b1) begin n_fail++; $display("FAIL full_resume_req: got %b want 1", dev_req_o); end
    n_cmp++; if (host_gnt_o !== 2'b01) begin n_fail++; $display("FAIL full_resume_gnt: got %b want 01", host_gnt_o); end
    next_cycle();
    host_req_i = 2'b00; dev_gnt_i = 1'b0; dev_rvalid_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      dev_rdata_i = 32'h20 + k;
      #1;
      n_cmp++; if (host_rvalid_o !== 2'b01) begin n_fail++; $display("FAIL full_drain_rvalid[%0d]: got %b want 01", k, host_rvalid_o); end
      next_cycle();
    end
    dev_rvalid_i = 1'b0; dev_rdata_i = '0;
    #1;
    n_cmp++; if (spurious_o !== 1'b0) begin n_fail++; $display("FAIL full_no_spurious: got %b want 0", spurious_o); end
    next_cycle();
  endtask

  task automatic test_spurious();
    dev_rvalid_i = 1'b1; dev_err_i = 1'b1; dev_rdata_i = 32'hBAD;
    #1;
    n_cmp++; if (host_rvalid_o !== 2'b00) begin n_fail++; $display("FAIL spur_rvalid: got %b want 00", host_rvalid_o); end
    n_cmp++; if (host_err_o !== 2'b00) begin n_fail++; $display("FAIL spur_err: got %b want 00", host_err_o); end
    n_cmp++; if (host_rdata_o !== 32'h0) begin n_fail++; $display("FAIL spur_rdata: got %h want 0", host_rdata_o); end
    next_cycle();
    dev_rvalid_i = 1'b0; dev_err_i = 1'b0; dev_rdata_i = '0;
    #1;
    n_cmp++; if (spurious_o !== 1'b1) begin n_fail++; $display("FAIL spur_flag: got %b want 1", spurious_o); end
    next_cycle();
    next_cycle();
    n_cmp++; if (spurious_o !== 1'b1) begin n_fail++; $display("FAIL spur_sticky: got %b want 1", spurious_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    #1;
    n_cmp++; if (spurious_o !== 1'b0) begin n_fail++; $display("FAIL mid_cleared: got %b want 0", spurious_o); end
    host_req_i = 2'b11; dev_gnt_i = 1'b1;
    #1;
    n_cmp++; if (host_gnt_o !== 2'b01) begin n_fail++; $display("FAIL mid_gnt0: got %b want 01", host_gnt_o); end
    next_cycle();
    #1;
    n_cmp++; if (host_gnt_o !== 2'b10) begin n_fail++; $display("FAIL mid_gnt1: got %b want 10", host_gnt_o); end
    next_cycle();
    host_req_i = 2'b00; dev_gnt_i = 1'b0;
    #2;
    rst_i = 1'b1; dev_rvalid_i = 1'b1; dev_rdata_i = 32'h33;
    #1;
    n_cmp++; if (host_rvalid_o !== 2'b00) begin n_fail++; $display("FAIL mid_in_reset_rvalid: got %b want 00", host_rvalid_o); end
    dev_rvalid_i = 1'b0;
    next_cycle();
    next_cycle();
    rst_i = 1'b0;
    dev_rvalid_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_cmp++; if (host_rvalid_o !== 2'b00) begin n_fail++; $display("FAIL mid_late_rvalid[%0d]: got %b want 00", k, host_rvalid_o); end
      next_cycle();
    end
    dev_rvalid_i = 1'b0; dev_rdata_i = '0;
    #1;
    n_cmp++; if (spurious_o !== 1'b1) begin n_fail++; $display("FAIL mid_spurious: got %b want 1", spurious_o); end
    next_cycle();
  endtask

`ifdef BUS_HOST_ARBITER_WATCHDOG_EN
  task automatic test_watchdog();
    do_reset();
    host_req_i = 2'b10; host_we_i = 2'b00; dev_gnt_i = 1'b1;
    #1;
    n_cmp++; if (host_gnt_o !== 2'b10) begin n_fail++; $display("FAIL wd_gnt: got %b want 10", host_gnt_o); end
    next_cycle();
    host_req_i = 2'b00; dev_gnt_i = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      #1;
      if (k < 16) begin
        n_cmp++; if (host_rvalid_o !== 2'b00) begin n_fail++; $display("FAIL wd_wait_rvalid[%0d]: got %b want 00", k, host_rvalid_o); end
      end else begin
        n_cmp++; if (host_rvalid_o !== 2'b10) begin n_fail++; $display("FAIL wd_timeout_rvalid: got %b want 10", host_rvalid_o); end
        n_cmp++; if (host_err_o !== 2'b10) begin n_fail++; $display("FAIL wd_timeout_err: got %b want 10", host_err_o); end
        n_cmp++; if (host_rdata_o !== 32'h0) begin n_fail++; $display("FAIL wd_timeout_rdata: got %h want 0", host_rdata_o); end
      end
      next_cycle();
    end
    dev_rvalid_i = 1'b1; dev_rdata_i = 32'h77;
    #1;
    n_cmp++; if (host_rvalid_o !== 2'b00) begin n_fail++; $display("FAIL wd_late_rvalid: got %b want 00", host_rvalid_o); end
    next_cycle();
    dev_rvalid_i = 1'b0; dev_rdata_i = '0;
    #1;
    n_cmp++; if (spurious_o !== 1'b0) begin n_fail++; $display("FAIL wd_late_spurious: got %b want 0", spurious_o); end
    next_cycle();
  endtask
`endif

  initial begin
    rst_i = 1'b1;
    host_req_i = '0; host_addr_i = '0; host_we_i = '0; host_be_i = '0; host_wdata_i = '0;
    dev_gnt_i = 1'b0; dev_rvalid_i = 1'b0; dev_rdata_i = '0; dev_err_i = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_spurious();
    test_reset_mid();
`ifdef BUS_HOST_ARBITER_WATCHDOG_EN
    test_watchdog();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
